// File: rtl/fns_dec_arb_if.sv
// -----------------------------------------------------------------------------
// fns_dec_arb_if
// Bundle of the request and result handshakes of the shared FNS decode
// scheduler.
//   req_valid [NREQ]      per-channel codeword valid      (requester -> arb)
//   req_code  [NREQ*20]   channel i codeword at [20i+19:20i]
//   req_ready [NREQ]      per-channel accept, one-hot/zero (arb -> requester)
//   out_valid             decoded word valid               (arb -> sink)
//   out_ready             downstream accept                (sink -> arb)
//   out_data  [FBLEN20]   decoded binary value
//   out_id    [IDW]       index of the channel that produced out_data
//   busy                  out_valid or any req_valid
// Modports: master = requester/sink side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface fns_dec_arb_if #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int FBLEN20 = 15
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*20-1:0] req_code;
   logic [NREQ-1:0]    req_ready;
   logic               out_valid;
   logic               out_ready;
   logic [FBLEN20-1:0] out_data;
   logic [IDW-1:0]     out_id;
   logic               busy;

   modport master (
      output req_valid, req_code, out_ready,
      input  req_ready, out_valid, out_data, out_id, busy
   );

   modport slave (
      input  req_valid, req_code, out_ready,
      output req_ready, out_valid, out_data, out_id, busy
   );
endinterface

// File: rtl/fns_dec_arb.sv
// -----------------------------------------------------------------------------
// fns_dec_arb
// Round-robin scheduler that shares one 20-bit FNS decoder between NREQ
// receive channels. One decode per cycle, registered and backpressurable
// output slot.
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fns_dec_arb_if.slave (request side, result side, busy)
// Decode: bit k of the codeword weighs FNS(k+1), FNS(1)=FNS(2)=1,
// FNS(n)=FNS(n-1)+FNS(n-2); the all-ones sum (17710) fits FBLEN20 = 15 bits.
// -----------------------------------------------------------------------------
module fns_dec_arb #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int FBLEN20 = 15
) (
   input logic          clk,
   input logic          rst,
   fns_dec_arb_if.slave bus
);

   // Fibonacci weight FNS(n); only ever called with constant n, so it folds
   // to a constant per codeword bit.
   function automatic logic [FBLEN20-1:0] fns_weight(input int n);
      logic [FBLEN20-1:0] a;
      logic [FBLEN20-1:0] b;
      logic [FBLEN20-1:0] t;
      a = FBLEN20'(1);
      b = FBLEN20'(1);
      for (int i = 1; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   logic               out_valid_q, out_valid_d;
   logic [FBLEN20-1:0] out_data_q,  out_data_d;
   logic [IDW-1:0]     out_id_q,    out_id_d;
   logic [IDW-1:0]     ptr_q,       ptr_d;

   logic               slot_free;
   logic               grant_found;
   logic [IDW-1:0]     grant_idx;
   logic               accept;
   logic [19:0]        grant_code;
   logic [FBLEN20-1:0] grant_dec;
   int                 cand;

   // Round-robin search starting at ptr_q, wrapping at NREQ.
   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int o = 0; o < NREQ; o++) begin
         cand = (int'(ptr_q) + o) % NREQ;
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(cand);
         end
      end
   end

   assign slot_free = !out_valid_q || bus.out_ready;
   // Gating with rst keeps req_ready quiet while reset holds the slot empty.
   assign accept    = slot_free && grant_found && !rst;

   always_comb begin
      bus.req_ready = '0;
      if (accept) begin
         bus.req_ready[grant_idx] = 1'b1;
      end
   end

   // Weighted-sum decode of the granted codeword.
   always_comb begin
      grant_code = bus.req_code[20*int'(grant_idx) +: 20];
      grant_dec  = '0;
      for (int k = 0; k < 20; k++) begin
         if (grant_code[k]) begin
            grant_dec = grant_dec + fns_weight(k + 1);
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      ptr_d       = ptr_q;
      if (slot_free) begin
         out_valid_d = accept;
         if (accept) begin
            out_data_d = grant_dec;
            out_id_d   = grant_idx;
            ptr_d      = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign bus.busy      = out_valid_q || (|bus.req_valid);

endmodule

// File: tb/tb_fns_dec_arb.sv
// -----------------------------------------------------------------------------
// tb_fns_dec_arb
// Directed vectors with hand-computed decodes, then a random soak against a
// bench-side arbitration model and a scoreboard of reference weighted sums.
// Inputs change 1 ns after the rising edge; outputs are sampled 4 ns after.
// -----------------------------------------------------------------------------
module tb_fns_dec_arb;

   localparam int NREQ    = 4;
   localparam int IDW     = 2;
   localparam int FBLEN20 = 15;

   // Hand-computed: FNS01 = 1, FNS20 = 6765, sum FNS01..FNS20 = 17710.
   // Round-robin channel i sends a single 1 at bit 4+i: FNS(5..8).
   localparam logic [14:0] DEC0 = 15'd5;
   localparam logic [14:0] DEC1 = 15'd8;
   localparam logic [14:0] DEC2 = 15'd13;
   localparam logic [14:0] DEC3 = 15'd21;

   typedef struct {
      logic [1:0]  id;
      logic [14:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   fns_dec_arb_if #(.NREQ(NREQ), .IDW(IDW), .FBLEN20(FBLEN20)) bus ();

   fns_dec_arb #(.NREQ(NREQ), .IDW(IDW), .FBLEN20(FBLEN20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference decode, written independently of the RTL: Fibonacci pair walk.
   function automatic logic [14:0] ref_dec(input logic [19:0] code);
      int a = 1;
      int b = 1;
      int s = 0;
      int t;
      for (int k = 0; k < 20; k++) begin
         if (code[k]) s += a;
         t = a + b;
         a = b;
         b = t;
      end
      return 15'(s);
   endfunction

   function automatic logic [14:0] rr_dec(input int ch);
      case (ch)
         0:       return DEC0;
         1:       return DEC1;
         2:       return DEC2;
         default: return DEC3;
      endcase
   endfunction

   // Called at edge+1; checks at edge+4, returns at next edge+1.
   task automatic sample(input string tag, input logic [3:0] exp_rdy, input logic exp_ov,
                         input logic [1:0] exp_id, input logic [14:0] exp_data);
      #3;
      check({tag, "_rdy"}, 32'(bus.req_ready), 32'(exp_rdy));
      check({tag, "_ov"}, 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov) begin
         check({tag, "_id"}, 32'(bus.out_id), 32'(exp_id));
         check({tag, "_data"}, 32'(bus.out_data), 32'(exp_data));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_rr_codes();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_code[i*20 +: 20] = 20'h1 << (4 + i);
      end
   endtask

   logic [19:0] sc_code [4];
   logic [14:0] sc_dec  [4];
   int          g2      [6];
   int          prev;
   exp_t        q [$];
   exp_t        e;
   int          m_ptr;
   logic        m_ov;
   logic        m_free;
   int          g;
   logic        found;
   logic [3:0]  exp_rdy;
   logic [3:0]  accepted;
   int          waitc [4];

   initial begin
      sc_code = '{20'h00001, 20'h80000, 20'h00000, 20'hFFFFF};
      sc_dec  = '{15'd1, 15'd6765, 15'd0, 15'd17710};
      g2      = '{0, 2, 3, 0, 2, 3};

      bus.req_valid = '0;
      bus.req_code  = '0;
      bus.out_ready = 1'b1;

      // ---------------- reset state ----------------
      #2;
      check("rst_ov", 32'(bus.out_valid), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_id", 32'(bus.out_id), 32'd0);
      check("rst_rdy", 32'(bus.req_ready), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // ---------------- single-channel decode on channel 2 ----------------
      for (int i = 0; i < 4; i++) begin
         bus.req_valid = 4'b0100;
         bus.req_code[2*20 +: 20] = sc_code[i];
         sample("single", 4'b0100, (i > 0), 2'd2, (i > 0) ? sc_dec[i-1] : 15'd0);
      end
      bus.req_valid = 4'b0000;
      sample("single_last", 4'b0000, 1'b1, 2'd2, sc_dec[3]);
      sample("single_idle", 4'b0000, 1'b0, 2'd0, 15'd0);

      // ---------------- reset mid-transfer ----------------
      set_rr_codes();
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b0010;
      sample("pend_acc", 4'b0010, 1'b0, 2'd0, 15'd0);
      bus.req_valid = 4'b0000;
      #3;
      check("pend_ov", 32'(bus.out_valid), 32'd1);
      check("pend_id", 32'(bus.out_id), 32'd1);
      check("pend_data", 32'(bus.out_data), 32'(DEC1));
      rst = 1'b1;
      #1;
      check("arst_ov", 32'(bus.out_valid), 32'd0);
      check("arst_data", 32'(bus.out_data), 32'd0);
      check("arst_id", 32'(bus.out_id), 32'd0);
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b1;
      #1;
      check("arst_rdy", 32'(bus.req_ready), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ---------------- round robin, all channels ----------------
      prev = -1;
      for (int n = 0; n < 8; n++) begin
         sample("rr4", 4'(1 << (n % 4)), (prev >= 0), 2'(prev), rr_dec(prev));
         prev = n % 4;
      end
      // Channel 1 drops out.
      bus.req_valid = 4'b1101;
      for (int n = 0; n < 6; n++) begin
         sample("rr3", 4'(1 << g2[n]), 1'b1, 2'(prev), rr_dec(prev));
         prev = g2[n];
      end

      // ---------------- backpressure after channel 3 accept ----------------
      bus.req_valid = 4'b1111;
      bus.out_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         sample("bp_hold", 4'b0000, 1'b1, 2'd3, DEC3);
      end
      bus.out_ready = 1'b1;
      sample("bp_release", 4'b0001, 1'b1, 2'd3, DEC3);
      sample("bp_next", 4'b0010, 1'b1, 2'd0, DEC0);

      // ---------------- random soak ----------------
      bus.req_valid = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ptr = 0;
      m_ov = 1'b0;
      accepted = '0;
      for (int i = 0; i < 4; i++) waitc[i] = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (cyc >= 9990) begin
            bus.req_valid = '0;
            bus.out_ready = 1'b1;
         end else begin
            for (int i = 0; i < NREQ; i++) begin
               if (!bus.req_valid[i] || accepted[i]) begin
                  bus.req_valid[i] = 1'($urandom_range(0, 1));
                  bus.req_code[i*20 +: 20] = 20'($urandom);
               end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
         end
         #3;
         m_free = !m_ov || bus.out_ready;
         found = 1'b0;
         g = 0;
         for (int o = 0; o < NREQ; o++) begin
            if (!found && bus.req_valid[(m_ptr + o) % NREQ]) begin
               found = 1'b1;
               g = (m_ptr + o) % NREQ;
            end
         end
         exp_rdy = (m_free && found) ? 4'(1 << g) : 4'b0000;
         check("soak_rdy", 32'(bus.req_ready), 32'(exp_rdy));
         check("soak_ov", 32'(bus.out_valid), 32'(m_ov));
         if (m_ov && bus.out_ready) begin
            if (q.size() == 0) begin
               check("soak_underflow", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("soak_id", 32'(bus.out_id), 32'(e.id));
               check("soak_data", 32'(bus.out_data), 32'(e.data));
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i]) waitc[i] = 0;
         end
         if (exp_rdy != 0) begin
            check("soak_wait", 32'(waitc[g] <= NREQ - 1), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
               if (i == g) waitc[i] = 0;
               else if (bus.req_valid[i]) waitc[i]++;
            end
            e.id = 2'(g);
            e.data = ref_dec(bus.req_code[g*20 +: 20]);
            q.push_back(e);
            m_ov = 1'b1;
            m_ptr = (g + 1) % NREQ;
         end else if (m_free) begin
            m_ov = 1'b0;
         end
         accepted = exp_rdy;
         @(posedge clk);
         #1;
      end
      check("soak_drained", 32'(q.size()), 32'd0);
      check("soak_idle_busy", 32'(bus.busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
